// File: rtl/uart_pkg.sv
// Shared definitions for the status-link UART (receiver FSM states, status characters).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  localparam logic [7:0] CHAR_M = 8'h4D;
  localparam logic [7:0] CHAR_S = 8'h53;

  // Moving flag after a decoded byte: set by 'M', cleared by 'S', otherwise held.
  function automatic logic next_moving(input logic cur, input logic [7:0] b);
    if (b == CHAR_M) begin
      return 1'b1;
    end else if (b == CHAR_S) begin
      return 1'b0;
    end
    return cur;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; both come out of reset at RESET_VAL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_status.sv
// 8N1 UART receiver for the status link: decodes 'M'/'S' into a moving flag and
// tracks link health with a watchdog on good frames.
module uart_rx_status
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = 100_000_000,
  parameter int unsigned BAUD           = 115200,
  parameter int unsigned TIMEOUT_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy,
  output logic       moving,
  output logic       link_ok
);

  // Bit period in clocks; expected to be at least 4 so the half-bit point exists.
  localparam int unsigned DIV  = CLK_FREQ / BAUD;
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);

  localparam logic [15:0]     HALF_LAST = 16'(DIV / 2 - 1);
  localparam logic [15:0]     BIT_LAST  = 16'(DIV - 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  logic            rxs;
  rx_state_t       state;
  logic [15:0]     div_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic [TO_W-1:0] to_cnt;
  logic [TO_W-1:0] to_next;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rxs)
  );

  // Receive FSM with shift register, character decode and registered pulse outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
      moving     <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            state   <= START;
            div_cnt <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        START: begin
          if (div_cnt == HALF_LAST) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            if (!rxs) begin
              state <= DATA;
            end else begin
              // Start bit did not hold to mid-bit: treat as a glitch.
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
        DATA: begin
          if (div_cnt == BIT_LAST) begin
            div_cnt <= '0;
            shift   <= {rxs, shift[7:1]};
            if (bit_cnt == 3'd7) begin
              state   <= STOP;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
        STOP: begin
          if (div_cnt == BIT_LAST) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            if (rxs) begin
              state      <= IDLE;
              busy       <= 1'b0;
              data       <= shift;
              data_valid <= 1'b1;
              moving     <= next_moving(moving, shift);
            end else begin
              state     <= WAIT_HIGH;
              frame_err <= 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
        WAIT_HIGH: begin
          // A held-low (break) line must not look like a new start bit.
          if (rxs) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            busy    <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          div_cnt <= '0;
          bit_cnt <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Saturating increment of the watchdog counter.
  always_comb begin
    to_next = (to_cnt == TO_LAST) ? to_cnt : to_cnt + TO_W'(1);
  end

  // Watchdog: a good frame restarts the count; link drops once it reaches the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt  <= '0;
      link_ok <= 1'b0;
    end else if (data_valid) begin
      to_cnt  <= '0;
      link_ok <= 1'b1;
    end else begin
      to_cnt <= to_next;
      if (to_next == TO_LAST) begin
        link_ok <= 1'b0;
      end
    end
  end

endmodule
